// File: rtl/imem_responder.sv
// imem_responder: memory side of the instruction-fetch interface.
// Word fetches are range/alignment checked, read from a synchronous array
// and returned through a stall-aware pipeline of LATENCY stages. A separate
// load port writes program words and ignores stall.
module imem_responder #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_mem_read,
  input  logic [31:0]              inst_mem_address,
  input  logic                     stall,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     inst_mem_is_valid,
  output logic [31:0]              inst_mem_read_data,
  output logic                     inst_mem_error
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

  // Request decode. The 33-bit subtraction exposes addresses below BASE in
  // bit 32; BASE is word aligned, so the low offset bits equal the address
  // low bits and serve as the misalignment test.
  logic [32:0]   offset;
  logic          misaligned;
  logic          out_of_range;
  logic          req_error;
  logic          rd_en;
  logic [AW-1:0] req_index;

  assign offset       = {1'b0, inst_mem_address} - {1'b0, BASE};
  assign misaligned   = (offset[1:0] != 2'b00);
  assign out_of_range = offset[32] || (offset[31:2] >= DEPTH_WORDS);
  assign req_error    = misaligned || out_of_range;
  assign req_index    = offset[AW+1:2];
  assign rd_en        = inst_mem_read && !stall && !req_error;

  // Program storage with a registered read port.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;

  // Load writes and fetch reads share the edge; the nonblocking update makes
  // a same-cycle read see the old word. The read register holds under stall.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
    if (rd_en) begin
      mem_q <= mem[req_index];
    end
  end

  // Per-stage view of the pipeline: valid, error and raw (pre-NOP) data.
  logic        stage_v [LATENCY];
  logic        stage_e [LATENCY];
  logic [31:0] stage_d [LATENCY];

  logic v0_reg;
  logic e0_reg;

  // First stage captures the accepted request. Its error flag resets high so
  // the output mux presents NOP out of reset; valid gating keeps the error
  // output low. The flag only changes on an accepted request, so the data
  // seen downstream holds across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_reg <= 1'b0;
      e0_reg <= 1'b1;
    end else if (!stall) begin
      v0_reg <= inst_mem_read;
      if (inst_mem_read) begin
        e0_reg <= req_error;
      end
    end
  end

  assign stage_v[0] = v0_reg;
  assign stage_e[0] = e0_reg;
  assign stage_d[0] = mem_q;

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      logic        v_reg;
      logic        e_reg;
      logic [31:0] d_reg;

      // Later stages shift when not stalled; payload only moves with a valid
      // entry so the final data holds its last value through bubbles.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_reg <= 1'b0;
          e_reg <= 1'b1;
          d_reg <= NOP;
        end else if (!stall) begin
          v_reg <= stage_v[gi-1];
          if (stage_v[gi-1]) begin
            e_reg <= stage_e[gi-1];
            d_reg <= stage_d[gi-1];
          end
        end
      end

      assign stage_v[gi] = v_reg;
      assign stage_e[gi] = e_reg;
      assign stage_d[gi] = d_reg;
    end
  endgenerate

  // Outputs come from the final stage; error entries return NOP.
  assign inst_mem_is_valid  = stage_v[LATENCY-1];
  assign inst_mem_error     = stage_v[LATENCY-1] && stage_e[LATENCY-1];
  assign inst_mem_read_data = stage_e[LATENCY-1] ? NOP : stage_d[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: four instances cover LATENCY 1/3/4 and
// a non-zero BASE; they share clock, reset and the load port.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        a_read, b_read, c_read, d_read;
  logic [31:0] a_addr, b_addr, c_addr, d_addr;
  logic        a_stall, b_stall, c_stall, d_stall;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic [31:0] a_data, b_data, c_data, d_data;
  logic        a_err, b_err, c_err, d_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [4];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(1024), .LATENCY(1), .BASE(32'h0), .NOP(NOP)) dut_a (
    .clk(clk), .reset(reset), .inst_mem_read(a_read), .inst_mem_address(a_addr),
    .stall(a_stall), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_mem_is_valid(a_valid), .inst_mem_read_data(a_data), .inst_mem_error(a_err));

  imem_responder #(.DEPTH(1024), .LATENCY(3), .BASE(32'h0), .NOP(NOP)) dut_b (
    .clk(clk), .reset(reset), .inst_mem_read(b_read), .inst_mem_address(b_addr),
    .stall(b_stall), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_mem_is_valid(b_valid), .inst_mem_read_data(b_data), .inst_mem_error(b_err));

  imem_responder #(.DEPTH(1024), .LATENCY(4), .BASE(32'h0), .NOP(NOP)) dut_c (
    .clk(clk), .reset(reset), .inst_mem_read(c_read), .inst_mem_address(c_addr),
    .stall(c_stall), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_mem_is_valid(c_valid), .inst_mem_read_data(c_data), .inst_mem_error(c_err));

  imem_responder #(.DEPTH(1024), .LATENCY(1), .BASE(32'h0000_1000), .NOP(NOP)) dut_d (
    .clk(clk), .reset(reset), .inst_mem_read(d_read), .inst_mem_address(d_addr),
    .stall(d_stall), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_mem_is_valid(d_valid), .inst_mem_read_data(d_data), .inst_mem_error(d_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-24s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_0193;
    prog[3] = 32'h0030_0213;

    reset = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    a_read = 0; b_read = 0; c_read = 0; d_read = 0;
    a_addr = 0; b_addr = 0; c_addr = 0; d_addr = 0;
    a_stall = 0; b_stall = 0; c_stall = 0; d_stall = 0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_data", a_data, NOP);
    check("rst_error", 32'(a_err), 32'd0);
    check("rst_data_lat4", c_data, NOP);
    reset = 1'b1;

    // Program load
    for (int i = 0; i < 4; i++) begin
      load_we = 1'b1; load_addr = 10'(i); load_data = prog[i];
      tick();
    end
    load_we = 1'b0;

    // Basic fetch, back-to-back, LATENCY=1
    a_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr = 32'(4 * i);
      tick();
      check($sformatf("fetch%0d_valid", i), 32'(a_valid), 32'd1);
      check($sformatf("fetch%0d_data", i), a_data, prog[i]);
      check($sformatf("fetch%0d_error", i), 32'(a_err), 32'd0);
    end
    a_read = 1'b0;
    tick();
    check("bubble_valid", 32'(a_valid), 32'd0);
    check("bubble_data_hold", a_data, prog[3]);

    // Misaligned and out-of-range fetches
    a_read = 1'b1; a_addr = 32'h0000_0006;
    tick();
    check("misalign_valid", 32'(a_valid), 32'd1);
    check("misalign_error", 32'(a_err), 32'd1);
    check("misalign_data", a_data, NOP);
    a_addr = 32'h0000_1000;
    tick();
    check("range_valid", 32'(a_valid), 32'd1);
    check("range_error", 32'(a_err), 32'd1);
    check("range_data", a_data, NOP);
    a_read = 1'b0;
    tick();
    check("err_bubble_error", 32'(a_err), 32'd0);
    check("err_bubble_data", a_data, NOP);

    // Non-zero BASE: underflow and a legal offset
    d_read = 1'b1; d_addr = 32'h0000_0FFC;
    tick();
    check("base_under_valid", 32'(d_valid), 32'd1);
    check("base_under_error", 32'(d_err), 32'd1);
    d_addr = 32'h0000_1004;
    tick();
    check("base_ok_error", 32'(d_err), 32'd0);
    check("base_ok_data", d_data, prog[1]);
    d_read = 1'b0;

    // LATENCY=3 with a two-cycle stall after the request
    b_read = 1'b1; b_addr = 32'h0000_0004;
    tick();
    b_read = 1'b0; b_stall = 1'b1;
    tick();
    check("stall1_valid", 32'(b_valid), 32'd0);
    tick();
    check("stall2_valid", 32'(b_valid), 32'd0);
    b_stall = 1'b0;
    tick();
    check("lat_c4_valid", 32'(b_valid), 32'd0);
    tick();
    check("lat_c5_valid", 32'(b_valid), 32'd1);
    check("lat_c5_data", b_data, prog[1]);
    b_stall = 1'b1;
    tick(); tick();
    check("hold_valid", 32'(b_valid), 32'd1);
    check("hold_data", b_data, prog[1]);
    b_stall = 1'b0;
    tick();
    check("consumed_valid", 32'(b_valid), 32'd0);
    check("consumed_data", b_data, prog[1]);

    // Load collision: same-cycle write and fetch of word 2
    load_we = 1'b1; load_addr = 10'd2; load_data = 32'hDEAD_BEEF;
    a_read = 1'b1; a_addr = 32'h0000_0008;
    tick();
    load_we = 1'b0;
    check("collide_old", a_data, prog[2]);
    tick();
    check("collide_new", a_data, 32'hDEAD_BEEF);
    a_read = 1'b0;
    tick();

    // Request presented during stall is dropped
    a_stall = 1'b1; a_read = 1'b1; a_addr = 32'h0000_0000;
    tick();
    check("drop_stalled", 32'(a_valid), 32'd0);
    a_stall = 1'b0; a_read = 1'b0;
    tick();
    check("drop_after1", 32'(a_valid), 32'd0);
    tick();
    check("drop_after2", 32'(a_valid), 32'd0);

    // LATENCY=4 reset mid-flight
    c_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_addr = 32'(4 * i);
      tick();
    end
    c_read = 1'b0;
    check("flight_valid", 32'(c_valid), 32'd1);
    check("flight_data", c_data, prog[0]);
    reset = 1'b0;
    #2;
    check("async_rst_valid", 32'(c_valid), 32'd0);
    check("async_rst_data", c_data, NOP);
    check("async_rst_error", 32'(c_err), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst%0d_valid", i), 32'(c_valid), 32'd0);
    end
    c_read = 1'b1; c_addr = 32'h0000_0008;
    tick();
    c_read = 1'b0;
    tick(); tick();
    check("mem_keep_early", 32'(c_valid), 32'd0);
    tick();
    check("mem_keep_valid", 32'(c_valid), 32'd1);
    check("mem_keep_data", c_data, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory side of the fetch interface that the IF/ID stage consumes through `inst_mem_is_valid` / `inst_mem_read_data`. It accepts word-fetch requests, returns the addressed instruction after a fixed, stall-aware pipeline latency, and flags misaligned or out-of-range fetches. A separate load port lets the boot loader or testbench write program words.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words. Power of two, 16..65536.
- `LATENCY`, 1: response latency in non-stalled cycles. Legal range 1..4.
- `BASE`, 32'h0000_0000: byte address of word 0. Word-aligned.
- `NOP`, 32'h0000_0013: data returned on error responses and at reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `inst_mem_read` in 1: fetch request strobe.
- `inst_mem_address` in 32: fetch byte address.
- `stall` in 1: freezes the response pipeline and holds the outputs.
- `load_we` in 1: program-load write enable.
- `load_addr` in log2(DEPTH): program-load word index.
- `load_data` in 32: program-load data.
- `inst_mem_is_valid` out 1: response valid, high for one non-stalled cycle per accepted request.
- `inst_mem_read_data` out 32: response instruction word.
- `inst_mem_error` out 1: response is for a misaligned or out-of-range address. Qualified by `inst_mem_is_valid`.

## Operation
- **Accept.** A request is accepted in a cycle with `inst_mem_read`=1 and `stall`=0. Requests during `stall`=1 are dropped; the requester must re-present them.
- **Address check.**
  - Word index = (`inst_mem_address` − `BASE`) >> 2.
  - Misaligned: `inst_mem_address[1:0]` != 0.
  - Out of range: address < `BASE`, or index >= `DEPTH`. Compute the subtraction in 33 bits so underflow is detected.
  - error = misaligned OR out of range.
- **Read.** Memory is a synchronous-read array. An error request does not read the array; it returns `NOP`.
- **Pipeline.** `LATENCY` stages, each holding {valid, error, data or index}. Every stage shifts only when `stall`=0. With `stall`=1, all stages and all outputs hold their values exactly.
- **Outputs.** Driven from the final stage:
  - `inst_mem_is_valid` = stage valid.
  - `inst_mem_read_data` = stage data. It holds its last value when valid=0 (no bubble zeroing).
  - `inst_mem_error` = stage error AND stage valid.
- **Load port.**
  - `load_we`=1 writes `load_data` to `mem[load_addr]` at the edge.
  - Writes happen independently of `stall`.
  - Read-first: a fetch reading the same word in the same cycle returns the old contents.
- **Reset.**
  - Pipeline valid bits clear. Outputs go to `inst_mem_is_valid`=0, `inst_mem_read_data`=`NOP`, `inst_mem_error`=0.
  - Memory contents are not cleared and survive reset.
  - Reset mid-operation discards all in-flight requests; nothing is emitted for them after reset is released.
- **Throughput.** One request accepted per non-stalled cycle. No internal backpressure; there is no ready signal.

## Timing
- A request accepted in cycle c produces its response in cycle c+`LATENCY`, provided no stall occurs in between. Each stalled cycle in between adds one cycle.
- `LATENCY`=1: request in cycle c, `inst_mem_is_valid`=1 with data in cycle c+1.
- Back-to-back requests in cycles c, c+1, c+2 produce valid in cycles c+L, c+L+1, c+L+2, in order, with no gaps.
- If `stall` rises while `inst_mem_is_valid`=1, valid and data stay asserted through the whole stall. The response counts as consumed in the first cycle after stall deasserts.
- `load_we` in cycle c becomes visible to a fetch accepted in cycle c+1 or later.
- Reset assertion clears the outputs asynchronously, without waiting for `clk`.

## Test plan
- **Basic fetch.** `LATENCY`=1. Load mem[0..3] = 32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213. Request addresses 0, 4, 8, 12 back-to-back → valid on 4 consecutive cycles with those words in order, `inst_mem_error`=0.
- **Latency and stall.** `LATENCY`=3. Request address 4, then hold `stall`=1 for 2 cycles starting the next cycle → valid appears 5 cycles after the request, data 32'h0010_0113. During a stall held while valid=1, valid and data stay asserted unchanged.
- **Errors.**
  - Request 32'h0000_0006 → valid=1, error=1, data=32'h0000_0013.
  - With `DEPTH`=1024, request 32'h0000_1000 → same error response.
  - With `BASE`=32'h0000_1000, request 32'h0000_0FFC → error=1 (underflow).
- **Load collision.** Write mem[2]=32'hDEAD_BEEF in the same cycle as a fetch of address 8 → that fetch returns the old word 32'h0020_0193. The next fetch of address 8 returns 32'hDEAD_BEEF.
- **Reset mid-flight.** `LATENCY`=4. Issue 3 requests, then assert `reset` for 1 cycle → outputs immediately 0 / `NOP` / 0, no valid for the in-flight requests afterwards, memory contents unchanged on later fetches.
- **Dropped request.** Assert `inst_mem_read`=1 with `stall`=1 → no response is ever produced for it.
